// File: rtl/pll_apb_reconfig_pkg.sv
// Shared types and constants for the PLL APB reconfiguration initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_apb_reconfig_pkg;

    localparam int ADDR_W_DEF        = 5;
    localparam int DATA_W_DEF        = 16;
    localparam int READY_TIMEOUT_DEF = 64;
    localparam int RST_HOLD_DEF      = 16;
    localparam int LOCK_STABLE_DEF   = 3;
    localparam int LOCK_TIMEOUT_DEF  = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_WR_SETUP,
        S_WR_ACCESS,
        S_RST_HOLD,
        S_WAIT_LOCK,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_APB_TO  = 2'b01;
    localparam logic [1:0] ERR_LOCK_TO = 2'b10;

endpackage

// File: rtl/pll_lock_sync.sv
// Synchronises the asynchronous PLL lock and qualifies it as stable lock.
// Latency: locked rises in the LOCK_STABLE-th consecutive synced-high cycle, falls with the synced value.
// Backpressure: none; free-running monitor.
// Ports: apb_clk/rst clock and sync reset; pll_lock raw lock; locked qualified lock; lock_fall one-cycle pulse when locked drops.
module pll_lock_sync #(
    parameter int LOCK_STABLE = 3
) (
    input  logic apb_clk,
    input  logic rst,
    input  logic pll_lock,
    output logic locked,
    output logic lock_fall
);

    localparam int CW = $clog2(LOCK_STABLE + 1);

    logic          sync1;
    logic          sync2;
    logic          locked_d;
    logic [CW-1:0] run_cnt;

    // run_cnt counts how many earlier cycles sync2 has been high in a row,
    // so the current high cycle completes the run when it reaches LOCK_STABLE-1.
    // Gating with sync2 makes locked fall in the same cycle the synced lock drops.
    assign locked    = sync2 && (run_cnt >= CW'(LOCK_STABLE - 1));
    assign lock_fall = locked_d && !locked;

    always_ff @(posedge apb_clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            run_cnt  <= '0;
            locked_d <= 1'b0;
        end else begin
            sync1    <= pll_lock;
            sync2    <= sync1;
            locked_d <= locked;
            if (!sync2) begin
                run_cnt <= '0;
            end else if (run_cnt < CW'(LOCK_STABLE - 1)) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_apb_reconfig.sv
// APB initiator for the PLL reconfiguration port: read, write, read-modify-write, optional relock.
// Latency: read/plain write respond 3 cycles after accept, RMW 5; +1 per APB wait state; relock adds hold + lock time.
// Backpressure: req_ready only in IDLE; APB waits bounded by READY_TIMEOUT, relock by LOCK_TIMEOUT.
// Ports: req_* request handshake; rsp_* one-cycle completion; apb_* requester side;
//        pll_rst/pll_lock PLL control; locked qualified lock; lock_lost sticky unexpected-loss flag.
module pll_apb_reconfig
    import pll_apb_reconfig_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int READY_TIMEOUT = READY_TIMEOUT_DEF,
    parameter int RST_HOLD      = RST_HOLD_DEF,
    parameter int LOCK_STABLE   = LOCK_STABLE_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF
) (
    input  logic              apb_clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_mask,
    input  logic              req_relock,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] apb_addr,
    output logic              apb_sel,
    output logic              apb_en,
    output logic              apb_write,
    output logic [DATA_W-1:0] apb_wdata,
    input  logic [DATA_W-1:0] apb_rdata,
    input  logic              apb_ready,
    output logic              pll_rst,
    input  logic              pll_lock,
    output logic              locked,
    output logic              lock_lost
);

    // One counter serves the access timeout, reset hold and lock timeout.
    localparam int CNT_MAX = (LOCK_TIMEOUT > READY_TIMEOUT)
                           ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                           : ((READY_TIMEOUT > RST_HOLD) ? READY_TIMEOUT : RST_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rmw_q;
    logic              relock_q;
    logic              lock_fall;
    logic              accept;

    assign accept = req_valid && req_ready;

    pll_lock_sync #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_sync (
        .apb_clk  (apb_clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .locked   (locked),
        .lock_fall(lock_fall)
    );

    always_ff @(posedge apb_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
            rmw_q     <= 1'b0;
            relock_q  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            busy      <= 1'b0;
            apb_addr  <= '0;
            apb_sel   <= 1'b0;
            apb_en    <= 1'b0;
            apb_write <= 1'b0;
            apb_wdata <= '0;
            pll_rst   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            // Lock drops during relock are expected; setting wins over clearing.
            if (lock_fall && state != S_RST_HOLD && state != S_WAIT_LOCK) begin
                lock_lost <= 1'b1;
            end else if (accept) begin
                lock_lost <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        apb_addr  <= req_addr;
                        apb_sel   <= 1'b1;
                        apb_en    <= 1'b0;
                        cnt       <= '0;
                        wdata_q   <= req_wdata;
                        mask_q    <= req_mask;
                        rdata_q   <= '0;
                        relock_q  <= req_write && req_relock;
                        rmw_q     <= req_write && (req_mask != '1);
                        if (req_write && (req_mask == '1)) begin
                            apb_write <= 1'b1;
                            apb_wdata <= req_wdata;
                            state     <= S_WR_SETUP;
                        end else begin
                            apb_write <= 1'b0;
                            state     <= S_RD_SETUP;
                        end
                    end
                end

                S_RD_SETUP: begin
                    apb_en <= 1'b1;
                    state  <= S_RD_ACCESS;
                end

                S_WR_SETUP: begin
                    apb_en <= 1'b1;
                    state  <= S_WR_ACCESS;
                end

                S_RD_ACCESS: begin
                    if (apb_ready) begin
                        apb_en  <= 1'b0;
                        rdata_q <= apb_rdata;
                        cnt     <= '0;
                        if (rmw_q) begin
                            // Keep sel high: the write setup phase follows directly.
                            apb_write <= 1'b1;
                            apb_wdata <= (apb_rdata & ~mask_q) | (wdata_q & mask_q);
                            state     <= S_WR_SETUP;
                        end else begin
                            apb_sel   <= 1'b0;
                            rsp_rdata <= apb_rdata;
                            rsp_err   <= ERR_OK;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
                        apb_sel   <= 1'b0;
                        apb_en    <= 1'b0;
                        rsp_rdata <= rdata_q;
                        rsp_err   <= ERR_APB_TO;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WR_ACCESS: begin
                    if (apb_ready) begin
                        apb_sel   <= 1'b0;
                        apb_en    <= 1'b0;
                        apb_write <= 1'b0;
                        cnt       <= '0;
                        if (relock_q) begin
                            pll_rst <= 1'b1;
                            state   <= S_RST_HOLD;
                        end else begin
                            rsp_rdata <= rdata_q;
                            rsp_err   <= ERR_OK;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
                        apb_sel   <= 1'b0;
                        apb_en    <= 1'b0;
                        apb_write <= 1'b0;
                        rsp_rdata <= rdata_q;
                        rsp_err   <= ERR_APB_TO;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RST_HOLD: begin
                    if (cnt == CNT_W'(RST_HOLD - 1)) begin
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (locked) begin
                        rsp_rdata <= rdata_q;
                        rsp_err   <= ERR_OK;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        rsp_rdata <= rdata_q;
                        rsp_err   <= ERR_LOCK_TO;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_apb_reconfig.md
Name: pll_apb_reconfig

Overview:
- APB initiator for the PLL's dynamic reconfiguration port. It is the requester side of the interface formed by apb_addr, apb_sel, apb_en, apb_write, apb_wdata, apb_rdata and apb_ready.
- Accepts single-register read, write and read-modify-write requests from a control block over a valid/ready handshake.
- Optionally performs a relock after a write: holds PLL reset, releases it, and waits for stable lock with a timeout.
- Monitors lock continuously and flags unexpected lock loss.

Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 16, APB data width.
- READY_TIMEOUT, 64, max access-phase cycles waiting for apb_ready.
- RST_HOLD, 16, cycles pll_rst is held high during relock.
- LOCK_STABLE, 3, consecutive synced-high cycles that count as locked.
- LOCK_TIMEOUT, 4096, max cycles from pll_rst release to stable lock.

Ports:
- apb_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write/RMW, 0=read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data.
- req_mask  in  DATA_W  bits to update; all-ones = plain write.
- req_relock  in  1  perform relock after write (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data (reads and RMW: pre-modify value).
- rsp_err  out  2  00 ok, 01 APB timeout, 10 lock timeout.
- busy  out  1  high whenever FSM not IDLE.
- apb_addr  out  ADDR_W.
- apb_sel  out  1.
- apb_en  out  1.
- apb_write  out  1.
- apb_wdata  out  DATA_W.
- apb_rdata  in  DATA_W.
- apb_ready  in  1.
- pll_rst  out  1  PLL reset.
- pll_lock  in  1  asynchronous PLL lock.
- locked  out  1  synced, stable lock.
- lock_lost  out  1  sticky; set on locked falling outside relock; cleared by rst or next accepted request.

Behaviour:
- Reset values: req_ready=0 during rst, then 1 in IDLE. All of the following reset to 0: rsp_valid, rsp_rdata, rsp_err, busy, apb_addr, apb_sel, apb_en, apb_write, apb_wdata, pll_rst, locked, lock_lost.
- FSM states: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, RST_HOLD, WAIT_LOCK, RESP.
- IDLE: req_ready=1. On accept, latch all request fields.
  - Read, or write with mask≠all-ones → RD_SETUP.
  - Write with mask=all-ones → WR_SETUP.
- SETUP states (one cycle): apb_sel=1, apb_en=0; addr, write and wdata driven and stable through the following ACCESS.
- ACCESS states: apb_sel=1, apb_en=1, held until apb_ready is sampled 1.
  - On that cycle, capture apb_rdata (reads only). Next cycle, sel and en return to 0.
- RD_ACCESS done:
  - Plain read → RESP.
  - RMW → WR_SETUP with wdata = (rdata & ~mask) | (req_wdata & mask).
- WR_ACCESS done: → RST_HOLD if req_relock, else RESP.
- APB timeout: an access counter counts ACCESS cycles. When it reaches READY_TIMEOUT without ready:
  - drop sel/en;
  - rsp_err=01 → RESP;
  - no relock; for RMW, no write is issued.
- RST_HOLD: pll_rst=1 for exactly RST_HOLD cycles, then 0 → WAIT_LOCK.
- WAIT_LOCK:
  - locked=1 → RESP with err 00.
  - If LOCK_TIMEOUT cycles elapse first → RESP with err 10.
- RESP: rsp_valid=1 for one cycle → IDLE. rsp_rdata and rsp_err are held until the next RESP.
- Latency with zero-wait-state APB (accept = cycle 0):
  - read: rsp_valid at cycle 3;
  - plain write without relock: cycle 3;
  - RMW: cycle 5.
  - Each wait state adds 1 cycle per access.
- Lock path:
  - 2-FF synchronizer on pll_lock.
  - locked rises after LOCK_STABLE consecutive synced-high cycles.
  - locked falls in the same cycle the synced value goes 0.
  - locked falling while state ∉ {RST_HOLD, WAIT_LOCK} sets lock_lost.
  - If lock_lost is being set in the same cycle a request is accepted, set wins.
- Synchronous rst mid-operation:
  - immediate return to IDLE; APB outputs go to 0 the next edge, with no completion of the transfer;
  - pll_rst is deasserted; no rsp_valid is generated.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package pll_apb_reconfig_pkg:
  - FSM state enum;
  - rsp_err codes ERR_OK, ERR_APB_TO, ERR_LOCK_TO;
  - default width constants.
- Sub-module pll_lock_sync:
  - 2-FF synchronizer;
  - LOCK_STABLE counter;
  - locked output and falling-edge pulse.

Test Plan:
1. Read addr 5'h03, PLL model returns 16'hA5C3 with zero wait → apb_sel rises cycle 1, apb_en cycle 2; rsp_valid at cycle 3; rsp_rdata=16'hA5C3, rsp_err=00.
2. RMW addr 5'h07, register=16'hFF00, wdata=16'h0055, mask=16'h00FF → one read then one write with apb_wdata=16'hFF55; rsp_rdata=16'hFF00; rsp_valid at cycle 5.
3. Write with relock, RST_HOLD=16; model raises pll_lock 100 cycles after pll_rst falls → pll_rst high exactly 16 cycles; rsp_valid ≈3+LOCK_STABLE cycles after lock rises; err=00; lock_lost stays 0.
4. apb_ready held 0 → sel/en drop after 64 access cycles; rsp_err=01; no write issued for RMW; pll_rst never asserted.
5. Relock where pll_lock never rises → rsp_err=10 exactly LOCK_TIMEOUT=4096 cycles after pll_rst release. Separately, drop pll_lock while IDLE → lock_lost=1 and sticky until the next accepted request.
6. Assert rst during WR_ACCESS, and again during RST_HOLD → next edge: apb_sel=apb_en=pll_rst=0, busy=0, no rsp_valid. A following read completes normally.
